de_bad_detect_mlane: RTL

- Parametrised, pipelined successor to the decode-stage bad-opcode detector.
- Checks up to LANES fetched instruction words per cycle against configurable illegal-opcode masks. Registers the per-lane result behind a valid/ready stage.
- Latches the first consumed fault (opcode, lane) in a sticky status block until the exception unit acknowledges it.
- Sits between fetch alignment and the decode/exception logic.

---
 rtl/de_bad_detect_mlane.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/de_bad_detect_mlane.sv
// rtl/de_bad_detect_mlane.sv - multi-lane illegal-opcode detector with one register stage and sticky fault capture
// Optional consumed-bad-lane counter: define DE_BADCNT_EN.
module de_bad_detect_mlane #(
    parameter int          LANES          = 2,
    parameter logic [63:0] BAD_MASK       = 64'h0000_080C_0FF0_080C,
    parameter logic [63:0] LONG_ONLY_MASK = 64'h0,
    parameter logic [7:0]  SHORT_BAD_MASK = 8'h80,
    parameter int          CNT_W          = 16,
    localparam int         LW             = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_en,
    input  logic [64*LANES-1:0]   in_opcode,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_bad,
    output logic                  out_any_bad,
    output logic [LW-1:0]         out_first_bad,
    output logic                  fault_pending,
    output logic [LW-1:0]         fault_lane,
    output logic [63:0]           fault_opcode,
    output logic                  fault_overrun,
    input  logic                  fault_ack,
    output logic [CNT_W-1:0]      bad_count
);

    typedef enum logic {IDLE, HELD} state_t;

    state_t              state, stateNext;
    logic [LANES-1:0]    laneBad;
    logic [LW-1:0]       firstBad;
    logic [64*LANES-1:0] opReg;
    logic [63:0]         selOp;
    logic [LW-1:0]       laneNext;
    logic [63:0]         opNext;
    logic                overrunNext;
    logic                xfer;
    logic                consume;

    function automatic logic classify(input logic [63:0] w);
        logic is16, is32, is64;
        is16 = ~w[63];
        is32 = (w[63:62] == 2'b10);
        is64 = (w[63:62] == 2'b11);
        return (is16 & SHORT_BAD_MASK[w[62:60]])
             | ((is32 | is64) & BAD_MASK[w[61:56]])
             | (is32 & LONG_ONLY_MASK[w[61:56]]);
    endfunction

    always_comb begin
        laneBad  = '0;
        firstBad = '0;
        for (int i = 0; i < LANES; i++) begin
            laneBad[i] = in_lane_en[i] & classify(in_opcode[64*i +: 64]);
        end
        // Scan downward so the lowest-index bad lane wins.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (laneBad[i]) firstBad = LW'(i);
        end
    end

    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;
    assign consume  = out_valid & out_ready & out_any_bad & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_bad       <= '0;
            out_any_bad   <= 1'b0;
            out_first_bad <= '0;
            opReg         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid     <= 1'b1;
            out_bad       <= laneBad;
            out_any_bad   <= |laneBad;
            out_first_bad <= firstBad;
            opReg         <= in_opcode;
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        selOp = opReg[63:0];
        for (int i = 0; i < LANES; i++) begin
            if (out_first_bad == LW'(i)) selOp = opReg[64*i +: 64];
        end
    end

    always_comb begin
        stateNext   = state;
        laneNext    = fault_lane;
        opNext      = fault_opcode;
        overrunNext = fault_overrun;
        case (state)
            IDLE: begin
                if (consume) begin
                    stateNext = HELD;
                    laneNext  = out_first_bad;
                    opNext    = selOp;
                end
            end
            HELD: begin
                if (fault_ack) begin
                    overrunNext = 1'b0;
                    if (consume) begin
                        laneNext = out_first_bad;
                        opNext   = selOp;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (consume) begin
                    overrunNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fault_lane    <= '0;
            fault_opcode  <= '0;
            fault_overrun <= 1'b0;
        end else begin
            state         <= stateNext;
            fault_lane    <= laneNext;
            fault_opcode  <= opNext;
            fault_overrun <= overrunNext;
        end
    end

    assign fault_pending = (state == HELD);

`ifdef DE_BADCNT_EN
    logic [CNT_W-1:0] cnt;
    logic [2:0]       popCnt;
    logic [CNT_W+2:0] cntSum;

    always_comb begin
        popCnt = '0;
        for (int i = 0; i < LANES; i++) begin
            popCnt = popCnt + {2'b00, out_bad[i]};
        end
        cntSum = {3'b000, cnt} + {{CNT_W{1'b0}}, popCnt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (consume) begin
            cnt <= (cntSum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
        end
    end

    assign bad_count = cnt;
`else
    assign bad_count = '0;
`endif

endmodule
